slow_clock_monitor: RTL

- Receiving end of the slow clock produced by the hit-statistics slow clock divider.
- Samples the slow clock (nominal 1024 × clk40M period) in the clk40M domain and emits single-cycle rise/fall strobes for downstream statistics windows.
- Measures each period and declares lock or loss-of-lock from period checks and timeouts.
- Keeps a saturating error counter for monitoring.

---
 rtl/slow_clock_monitor.sv | 136 +++++++++++++
 1 files changed

// File: rtl/slow_clock_monitor.sv
// Slow clock monitor: brings the divided slow clock into clk40M and emits edge strobes.
// It also measures each period, tracks lock and loss of lock, and keeps a saturating error count.
//
// state  | meaning
// IDLE   | no reference edge yet; the next rise only starts a measurement
// ACQ    | measuring periods, counting consecutive good ones
// LOCKED | LOCK_COUNT good periods seen; a bad period or a timeout breaks lock
module slow_clock_monitor #(
  parameter int unsigned EXPECTED_PERIOD = 1024,
  parameter int unsigned TOLERANCE       = 4,
  parameter int unsigned LOCK_COUNT      = 4,
  parameter int unsigned CNT_WIDTH       = 12,
  parameter int unsigned ERR_WIDTH       = 8
) (
  input  logic                 clk40M,
  input  logic                 rst_n,
  input  logic                 clk_slow_in,
  output logic                 rise_tick,
  output logic                 fall_tick,
  output logic                 period_valid,
  output logic [CNT_WIDTH-1:0] period_value,
  output logic                 locked,
  output logic [ERR_WIDTH-1:0] err_count
);
  localparam int unsigned GOOD_WIDTH = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_WIDTH:0]    P_MIN       = (CNT_WIDTH+1)'(EXPECTED_PERIOD - TOLERANCE);
  localparam logic [CNT_WIDTH:0]    P_MAX       = (CNT_WIDTH+1)'(EXPECTED_PERIOD + TOLERANCE);
  localparam logic [CNT_WIDTH-1:0]  CNT_TIMEOUT = CNT_WIDTH'(EXPECTED_PERIOD + TOLERANCE);
  localparam logic [GOOD_WIDTH-1:0] GOOD_LOCK   = GOOD_WIDTH'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

  state_t                 state, state_nxt;
  logic [GOOD_WIDTH-1:0]  good_cnt, good_nxt, good_inc;
  logic                   err_inc;
  logic                   sync_meta, sync_q, hist_q;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH:0]     p_meas;
  logic [CNT_WIDTH-1:0]   p_sat;
  logic                   period_good, timeout;

  always_ff @(posedge clk40M) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      hist_q    <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end else begin
      sync_meta <= clk_slow_in;
      sync_q    <= sync_meta;
      hist_q    <= sync_q;
      rise_tick <= sync_q & ~hist_q;
      fall_tick <= ~sync_q & hist_q;
    end
  end

  always_ff @(posedge clk40M) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (rise_tick) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

  // cnt holds period-1 on the rise cycle; one extra bit so the +1 cannot wrap
  assign p_meas      = {1'b0, cnt} + (CNT_WIDTH+1)'(1);
  assign p_sat       = p_meas[CNT_WIDTH] ? '1 : p_meas[CNT_WIDTH-1:0];
  assign period_good = (p_meas >= P_MIN) && (p_meas <= P_MAX);
  assign timeout     = (state != IDLE) && (cnt == CNT_TIMEOUT) && !rise_tick;
  assign good_inc    = good_cnt + GOOD_WIDTH'(1);

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    err_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (rise_tick) begin
          state_nxt = ACQ;
          good_nxt  = '0;
        end
      end
      ACQ: begin
        if (rise_tick) begin
          if (period_good) begin
            good_nxt = good_inc;
            if (good_inc == GOOD_LOCK) state_nxt = LOCKED;
          end else begin
            good_nxt = '0;
          end
        end else if (timeout) begin
          state_nxt = IDLE;
        end
      end
      LOCKED: begin
        if (rise_tick && !period_good) begin
          state_nxt = ACQ;
          good_nxt  = '0;
          err_inc   = 1'b1;
        end else if (timeout) begin
          state_nxt = IDLE;
          err_inc   = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        good_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk40M) begin
    if (!rst_n) begin
      state        <= IDLE;
      good_cnt     <= '0;
      locked       <= 1'b0;
      err_count    <= '0;
      period_value <= '0;
      period_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      good_cnt     <= good_nxt;
      locked       <= (state_nxt == LOCKED);
      period_valid <= 1'b0;
      if (err_inc && (err_count != '1)) err_count <= err_count + ERR_WIDTH'(1);
      // the first rise after IDLE has no reference edge, so no period is reported
      if (rise_tick && (state != IDLE)) begin
        period_value <= p_sat;
        period_valid <= 1'b1;
      end
    end
  end
endmodule
